// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX pipeline slice: reset PC, default widths,
// forwarding select encoding and control-bundle field offsets.
package pipe_pkg;

  localparam int          XLEN_DEF   = 32;
  localparam logic [31:0] PC_RST_VAL = 32'hFFFF_FFFC;

  // Select value that picks the register-file read data instead of a bypass.
  localparam int FWD_RF = 0;

  // Field offsets inside the opaque control bundle (decoder and EX agree on these).
  localparam int CTRL_ALU_SEL_LSB = 0;
  localparam int CTRL_ALU_SEL_W   = 4;
  localparam int CTRL_WD_SEL_LSB  = 4;
  localparam int CTRL_WD_SEL_W    = 2;
  localparam int CTRL_BRANCH_BIT  = 6;
  localparam int CTRL_DRAM_WE_BIT = 7;
  localparam int CTRL_RS2_SEL_BIT = 8;

  // Select width needed to encode "register file" plus num_fwd bypass sources.
  function automatic int sel_width(input int num_fwd);
    return $clog2(num_fwd + 1);
  endfunction

endpackage

// File: rtl/fwd_operand_mux.sv
// One operand channel of the forwarding network: picks the register-file value
// or one bypass source, and flags select codes that name no source.
module fwd_operand_mux
  import pipe_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NUM_FWD = 4,
  parameter int SEL_W   = sel_width(NUM_FWD)
) (
  input  logic [XLEN-1:0]         rs_data,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [XLEN-1:0]         operand,
  output logic                    sel_err
);

  // Out-of-range codes fall back to the register file so EX still sees a sane value.
  always_comb begin
    operand = rs_data;
    sel_err = 1'b0;
    if (sel != SEL_W'(FWD_RF)) begin
      if (sel > SEL_W'(NUM_FWD)) begin
        sel_err = 1'b1;
      end else begin
        for (int j = 0; j < NUM_FWD; j++) begin
          if (sel == SEL_W'(j + 1)) operand = fwd_data[j*XLEN +: XLEN];
        end
      end
    end
  end

endmodule

// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with valid/ready handshake. Operand forwarding is
// resolved when the instruction is captured, so EX only sees final operands.
module id_ex_fwd_stage
  import pipe_pkg::*;
#(
  parameter int              XLEN    = XLEN_DEF,
  parameter int              NUM_OPS = 2,
  parameter int              NUM_FWD = 4,
  parameter int              CTRL_W  = 16,
  parameter int              RD_W    = 5,
  parameter int              CNT_W   = 16,
  parameter logic [XLEN-1:0] PC_RST  = XLEN'(PC_RST_VAL),
  localparam int             SEL_W   = sel_width(NUM_FWD)
) (
  input  logic                      clk_cpu,
  input  logic                      rst_cpu,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           in_pc,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [RD_W-1:0]           in_rd,
  input  logic                      in_rd_we,
  input  logic [XLEN-1:0]           in_imm,
  input  logic [NUM_OPS*XLEN-1:0]   in_rs_data,
  input  logic [NUM_OPS*SEL_W-1:0]  in_fwd_sel,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_pc,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [RD_W-1:0]           out_rd,
  output logic                      out_rd_we,
  output logic [XLEN-1:0]           out_imm,
  output logic [NUM_OPS*XLEN-1:0]   out_op,
  output logic                      out_flushed,
  output logic                      fwd_err,
  output logic [CNT_W-1:0]          bubble_cnt
);

  logic                    valid_reg;
  logic [XLEN-1:0]         pc_reg;
  logic [CTRL_W-1:0]       ctrl_reg;
  logic [RD_W-1:0]         rd_reg;
  logic                    rd_we_reg;
  logic [XLEN-1:0]         imm_reg;
  logic [NUM_OPS*XLEN-1:0] op_reg;
  logic                    flushed_reg;
  logic                    err_reg;
  logic [CNT_W-1:0]        bubble_reg;

  logic [NUM_OPS*XLEN-1:0] op_next;
  logic [NUM_OPS-1:0]      sel_err_vec;
  logic                    stall;
  logic                    load;
  logic                    drain;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPS; gi++) begin : g_op
      fwd_operand_mux #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD),
        .SEL_W   (SEL_W)
      ) u_mux (
        .rs_data  (in_rs_data[gi*XLEN +: XLEN]),
        .fwd_data (fwd_data),
        .sel      (in_fwd_sel[gi*SEL_W +: SEL_W]),
        .operand  (op_next[gi*XLEN +: XLEN]),
        .sel_err  (sel_err_vec[gi])
      );
    end
  endgenerate

  assign in_ready = !valid_reg || out_ready;
  assign stall    = valid_reg && !out_ready;
  assign load     = in_valid && in_ready && !flush;
  assign drain    = in_ready && !in_valid && !flush;

  // Stage state, priority reset > flush > stall > load > drain.
  always_ff @(posedge clk_cpu) begin
    if (rst_cpu) begin
      valid_reg   <= 1'b0;
      pc_reg      <= PC_RST;
      ctrl_reg    <= '0;
      rd_reg      <= '0;
      rd_we_reg   <= 1'b0;
      imm_reg     <= '0;
      op_reg      <= '0;
      flushed_reg <= 1'b0;
      err_reg     <= 1'b0;
      bubble_reg  <= '0;
    end else begin
      flushed_reg <= flush;
      if (flush) begin
        valid_reg <= 1'b0;
        pc_reg    <= PC_RST;
        ctrl_reg  <= '0;
        rd_reg    <= '0;
        rd_we_reg <= 1'b0;
        imm_reg   <= '0;
        op_reg    <= '0;
      end else if (stall) begin
        valid_reg <= valid_reg;
      end else if (load) begin
        valid_reg <= 1'b1;
        pc_reg    <= in_pc;
        ctrl_reg  <= in_ctrl;
        rd_reg    <= in_rd;
        // Writes to x0 are dropped here so later stages never need to check.
        rd_we_reg <= in_rd_we && (in_rd != '0);
        imm_reg   <= in_imm;
        op_reg    <= op_next;
        if (|sel_err_vec) err_reg <= 1'b1;
      end else if (drain) begin
        // Kill control so EX treats the stale payload as a NOP.
        valid_reg <= 1'b0;
        ctrl_reg  <= '0;
        rd_we_reg <= 1'b0;
        if (bubble_reg != '1) bubble_reg <= bubble_reg + 1'b1;
      end
    end
  end

  assign out_valid   = valid_reg;
  assign out_pc      = pc_reg;
  assign out_ctrl    = ctrl_reg;
  assign out_rd      = rd_reg;
  assign out_rd_we   = rd_we_reg;
  assign out_imm     = imm_reg;
  assign out_op      = op_reg;
  assign out_flushed = flushed_reg;
  assign fwd_err     = err_reg;
  assign bubble_cnt  = bubble_reg;

endmodule

// File: doc/id_ex_fwd_stage.md
Name: id_ex_fwd_stage

Overview:
Parametrised ID/EX pipeline register that captures decoded instruction state and resolves operand forwarding at capture time. It supports NUM_OPS operand channels, each fed from the register file or from one of NUM_FWD bypass sources. It sits between the decode stage and the ALU/branch unit. Compared with the fixed two-operand stage it adds a valid/ready handshake, flush-over-stall priority, x0 write suppression, a select-error flag and a bubble counter.

Parameters:
XLEN, 32, datapath width
NUM_OPS, 2, operand channels (>=1)
NUM_FWD, 4, bypass sources (>=1); SEL_W = clog2(NUM_FWD+1)
CTRL_W, 16, opaque packed control bundle width (alu_sel, wd_sel, branch, dram_we, rs2_sel...)
RD_W, 5, destination register index width
CNT_W, 16, bubble counter width
PC_RST, 32'hFFFF_FFFC, PC value on reset/flush

Ports:
clk_cpu  in  1  clock; all state on rising edge
rst_cpu  in  1  synchronous active-high reset
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage can accept this cycle
in_pc  in  XLEN  instruction PC
in_ctrl  in  CTRL_W  control bundle
in_rd  in  RD_W  destination index
in_rd_we  in  1  register write enable
in_imm  in  XLEN  immediate
in_rs_data  in  NUM_OPS*XLEN  register-file read data; channel k at [k*XLEN +: XLEN]
in_fwd_sel  in  NUM_OPS*SEL_W  per-channel select: 0 = register file, j (1..NUM_FWD) = fwd source j-1
fwd_data  in  NUM_FWD*XLEN  bypass values (ex result, ex imm, mem data, wb data...)
flush  in  1  kill stage contents
out_valid  out  1  EX holds a live instruction
out_ready  in  1  EX consumes this cycle
out_pc, out_ctrl, out_rd, out_rd_we, out_imm  out  as inputs  registered copies
out_op  out  NUM_OPS*XLEN  resolved operands
out_flushed  out  1  high exactly one cycle after a flush cycle
fwd_err  out  1  sticky: an out-of-range select was captured
bubble_cnt  out  CNT_W  saturating count of bubble cycles

Behaviour:
- Reset (rst_cpu=1 at an edge): out_valid=0, out_pc=PC_RST, out_ctrl=0, out_rd=0, out_rd_we=0, out_imm=0, out_op=0, out_flushed=0, fwd_err=0, bubble_cnt=0. Reset overrides all other inputs, including mid-stall.
- in_ready = !out_valid || out_ready (combinational); load = in_valid && in_ready && !flush.
- Edge priority: rst_cpu > flush > stall > load > drain.
- Flush: out_valid<=0; pc/ctrl/rd/rd_we/imm/op take reset values; out_flushed<=1. The input is discarded even when in_valid=1. Flush wins over stall; this is intentional and differs from the previous stage.
- Stall (out_valid && !out_ready && !flush): every output register holds; in_ready=0.
- Load: latency 1. Fields are copied and out_valid<=1. out_rd_we <= in_rd_we && (in_rd != 0).
- Operand k on load = sel_k==0 ? in_rs_data[k] : (sel_k<=NUM_FWD ? fwd_data[sel_k-1] : in_rs_data[k]). An out-of-range select also sets fwd_err<=1. fwd_err is cleared only by reset.
- Drain (out_ready=1 or !out_valid, with !in_valid, no flush): out_valid<=0. out_ctrl and out_rd_we<=0 so that EX sees a NOP. pc/rd/imm/op hold.
- bubble_cnt increments by 1 on each drain cycle and saturates at all-ones. Flush cycles are not counted.
- out_flushed<=flush on every non-reset edge, including during stall.
- Forwarding muxes use the sel value sampled at the load edge only. A select change during stall has no effect.

Decomposition:
- Shared package (pipe_pkg): PC_RST, XLEN default, SEL_W function (clog2), FWD_RF=0 encoding constant, control-bundle field offsets.
- One sub-module: fwd_operand_mux (one per channel via generate). Inputs: rs_data, fwd_data vector, sel. Outputs: operand and out-of-range flag. It is purely combinational. The registers stay in id_ex_fwd_stage.

Test Plan:
- Reset then idle: rst_cpu=1 for 2 cycles, in_valid=0 -> out_valid=0, out_pc=FFFF_FFFC, bubble_cnt increments from 0 to 3 over 3 idle cycles after reset.
- Forward select: in_rs_data ch0=0x11, ch1=0x22, fwd_data[2]=0xDEAD, sel ch0=3, ch1=0, load -> next cycle out_op ch0=0xDEAD, ch1=0x22, out_valid=1, fwd_err=0.
- Stall hold: out_valid=1, out_ready=0 for 3 cycles while in_pc changes 0x100->0x104 -> in_ready=0, out_pc stays 0x100; out_ready=1 -> 0x104 captured next edge.
- Flush beats stall: out_valid=1, out_ready=0, flush=1 -> out_valid=0, out_pc=FFFF_FFFC, out_flushed=1 for exactly one cycle, bubble_cnt unchanged.
- x0 and bad select: in_rd=0, in_rd_we=1, sel ch1=7 (NUM_FWD=4) -> out_rd_we=0, out_op ch1=in_rs_data ch1, fwd_err=1 and remains 1 until reset.
- Saturation: CNT_W=4, 20 drain cycles -> bubble_cnt=15 held; synchronous reset mid-sequence -> 0 on next edge.
